// File: rtl/aemb2_xsl_hub_pkg.sv
// aemb2_xsl_hub_pkg
//   Shared definitions for the XSL link hub: FIFO entry layout, controller
//   state encodings and the parameter legality check used at elaboration.
package aemb2_xsl_hub_pkg;

    // FIFO entry: {ctl, data[31:0]}
    localparam int XSL_DAT_W = 32;
    localparam int XSL_ENT_W = 33;
    localparam int XSL_CTL_B = 32;

    // Controller states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // Legal when 1 <= channels <= 2^addr_width and depth is at least 2.
    function automatic bit xsl_params_ok(input int xwb, input int xch, input int fdp);
        return (xwb >= 1) && (xwb <= 16) && (xch >= 1) && (xch <= (1 << xwb)) && (fdp >= 1);
    endfunction

endpackage

// File: rtl/aemb2_xsl_fifo.sv
// aemb2_xsl_fifo
//   Single-clock FIFO, depth 2^AEMB_FDP, asynchronous active-high reset.
//   Pushes into a full FIFO and pops from an empty FIFO are ignored, so a
//   push is refused on a full FIFO even if a pop happens in the same cycle.
//   Ports:
//     i_clk, i_rst       clock, async reset
//     i_push, i_din      write request and data
//     i_pop              read request (head advances)
//     o_full, o_empty    occupancy status
//     o_head             entry at the read pointer (combinational)
module aemb2_xsl_fifo
    import aemb2_xsl_hub_pkg::*;
#(
    parameter int WIDTH    = XSL_ENT_W,
    parameter int AEMB_FDP = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned      DEPTH   = 1 << AEMB_FDP;
    localparam logic [AEMB_FDP:0] PTR_ONE = {{AEMB_FDP{1'b0}}, 1'b1};

    logic [AEMB_FDP:0] r_wptr;
    logic [AEMB_FDP:0] r_rptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_push;
    logic              w_pop;

    // Extra MSB on the pointers separates full (MSBs differ) from empty.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AEMB_FDP] != r_rptr[AEMB_FDP]) &&
                     (r_wptr[AEMB_FDP-1:0] == r_rptr[AEMB_FDP-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rptr[AEMB_FDP-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AEMB_FDP-1:0]] <= i_din;
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/aemb2_xsl_hub.sv
// aemb2_xsl_hub
//   Multi-channel XSL link hub between the core's XSL master port and up to
//   2^AEMB_XWB stream channels, each with a TX and an RX FIFO.
//   Ports:
//     sys_clk_i, sys_rst_i        clock, async active-high reset
//     xwb_cyc_i, xwb_stb_i        request qualifiers
//     xwb_wre_i                   1 = put (TX), 0 = get (RX)
//     xwb_adr_i                   channel number
//     xwb_tag_i                   control bit written on put / expected on get
//     xwb_nbk_i                   non-blocking transaction
//     xwb_dat_i / xwb_dat_o       put data / get data (valid with ack)
//     xwb_ack_o                   one-cycle transaction complete
//     xsl_flg_o                   non-blocking op failed (valid with ack)
//     xsl_err_o                   control mismatch or bad channel (valid with ack)
//     txd_dat_o/ctl_o/vld_o       TX FIFO heads, per channel
//     txd_rdy_i                   TX consumer ready, per channel
//     rxd_dat_i/ctl_i/vld_i       RX producer data, per channel
//     rxd_rdy_o                   RX FIFO not full, per channel
module aemb2_xsl_hub
    import aemb2_xsl_hub_pkg::*;
#(
    parameter int AEMB_XWB = 3,
    parameter int AEMB_XCH = 8,
    parameter int AEMB_FDP = 2
) (
    input  logic                            sys_clk_i,
    input  logic                            sys_rst_i,
    input  logic                            xwb_cyc_i,
    input  logic                            xwb_stb_i,
    input  logic                            xwb_wre_i,
    input  logic [AEMB_XWB-1:0]             xwb_adr_i,
    input  logic                            xwb_tag_i,
    input  logic                            xwb_nbk_i,
    input  logic [XSL_DAT_W-1:0]            xwb_dat_i,
    output logic [XSL_DAT_W-1:0]            xwb_dat_o,
    output logic                            xwb_ack_o,
    output logic                            xsl_flg_o,
    output logic                            xsl_err_o,
    output logic [XSL_DAT_W*AEMB_XCH-1:0]   txd_dat_o,
    output logic [AEMB_XCH-1:0]             txd_ctl_o,
    output logic [AEMB_XCH-1:0]             txd_vld_o,
    input  logic [AEMB_XCH-1:0]             txd_rdy_i,
    input  logic [XSL_DAT_W*AEMB_XCH-1:0]   rxd_dat_i,
    input  logic [AEMB_XCH-1:0]             rxd_ctl_i,
    input  logic [AEMB_XCH-1:0]             rxd_vld_i,
    output logic [AEMB_XCH-1:0]             rxd_rdy_o
);

    localparam int NPAD = 1 << AEMB_XWB;

    if (!xsl_params_ok(AEMB_XWB, AEMB_XCH, AEMB_FDP)) begin : g_bad_params
        $error("aemb2_xsl_hub: illegal AEMB_XWB/AEMB_XCH/AEMB_FDP combination");
    end

    // Channel status is padded to the full address space so the selected
    // channel can be indexed directly by xwb_adr_i; unimplemented slots
    // read as full/empty/not-implemented.
    logic [NPAD-1:0]      w_chn_impl;
    logic [NPAD-1:0]      w_tx_full;
    logic [NPAD-1:0]      w_rx_empty;
    logic [XSL_ENT_W-1:0] w_rx_head [NPAD];
    logic [AEMB_XCH-1:0]  w_tx_push;
    logic [AEMB_XCH-1:0]  w_rx_pop;

    logic [0:0]           r_state;
    logic [XSL_DAT_W-1:0] r_dat;
    logic                 r_flg;
    logic                 r_err;

    logic                 w_req;
    logic                 w_chn_ok;
    logic                 w_sel_full;
    logic                 w_sel_empty;
    logic [XSL_ENT_W-1:0] w_sel_head;
    logic                 w_fire;
    logic [XSL_DAT_W-1:0] w_nxt_dat;
    logic                 w_nxt_flg;
    logic                 w_nxt_err;

    for (genvar c = 0; c < NPAD; c++) begin : g_ch
        if (c < AEMB_XCH) begin : g_impl
            logic                 w_tx_empty;
            logic                 w_rx_full;
            logic [XSL_ENT_W-1:0] w_tx_head;

            assign w_chn_impl[c] = 1'b1;
            assign w_tx_push[c]  = w_fire & xwb_wre_i & (xwb_adr_i == AEMB_XWB'(c));
            assign w_rx_pop[c]   = w_fire & ~xwb_wre_i & (xwb_adr_i == AEMB_XWB'(c));

            aemb2_xsl_fifo #(
                .WIDTH    (XSL_ENT_W),
                .AEMB_FDP (AEMB_FDP)
            ) u_tx (
                .i_clk   (sys_clk_i),
                .i_rst   (sys_rst_i),
                .i_push  (w_tx_push[c]),
                .i_din   ({xwb_tag_i, xwb_dat_i}),
                .i_pop   (txd_rdy_i[c]),
                .o_full  (w_tx_full[c]),
                .o_empty (w_tx_empty),
                .o_head  (w_tx_head)
            );

            assign txd_dat_o[c*XSL_DAT_W +: XSL_DAT_W] = w_tx_head[XSL_DAT_W-1:0];
            assign txd_ctl_o[c] = w_tx_head[XSL_CTL_B];
            assign txd_vld_o[c] = ~w_tx_empty;

            aemb2_xsl_fifo #(
                .WIDTH    (XSL_ENT_W),
                .AEMB_FDP (AEMB_FDP)
            ) u_rx (
                .i_clk   (sys_clk_i),
                .i_rst   (sys_rst_i),
                .i_push  (rxd_vld_i[c]),
                .i_din   ({rxd_ctl_i[c], rxd_dat_i[c*XSL_DAT_W +: XSL_DAT_W]}),
                .i_pop   (w_rx_pop[c]),
                .o_full  (w_rx_full),
                .o_empty (w_rx_empty[c]),
                .o_head  (w_rx_head[c])
            );

            assign rxd_rdy_o[c] = ~w_rx_full;
        end else begin : g_pad
            assign w_chn_impl[c] = 1'b0;
            assign w_tx_full[c]  = 1'b1;
            assign w_rx_empty[c] = 1'b1;
            assign w_rx_head[c]  = '0;
        end
    end

    assign w_req       = xwb_cyc_i & xwb_stb_i & (r_state == ST_IDLE);
    assign w_chn_ok    = w_chn_impl[xwb_adr_i];
    assign w_sel_full  = w_tx_full[xwb_adr_i];
    assign w_sel_empty = w_rx_empty[xwb_adr_i];
    assign w_sel_head  = w_rx_head[xwb_adr_i];

    // Complete on: bad channel, non-blocking, or the FIFO condition met.
    assign w_fire = w_req & (~w_chn_ok | xwb_nbk_i |
                             (xwb_wre_i ? ~w_sel_full : ~w_sel_empty));

    // A fired request with a full TX / empty RX can only be non-blocking.
    always_comb begin
        w_nxt_dat = '0;
        w_nxt_flg = 1'b0;
        w_nxt_err = 1'b0;
        if (!w_chn_ok) begin
            w_nxt_err = 1'b1;
        end else if (xwb_wre_i) begin
            w_nxt_flg = w_sel_full;
        end else if (w_sel_empty) begin
            w_nxt_flg = 1'b1;
        end else begin
            w_nxt_dat = w_sel_head[XSL_DAT_W-1:0];
            w_nxt_err = w_sel_head[XSL_CTL_B] ^ xwb_tag_i;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state <= ST_IDLE;
            r_dat   <= '0;
            r_flg   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_fire) begin
            r_state <= ST_ACK;
            r_dat   <= w_nxt_dat;
            r_flg   <= w_nxt_flg;
            r_err   <= w_nxt_err;
        end else begin
            r_state <= ST_IDLE;
            r_dat   <= '0;
            r_flg   <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign xwb_ack_o = (r_state == ST_ACK);
    assign xwb_dat_o = r_dat;
    assign xsl_flg_o = r_flg;
    assign xsl_err_o = r_err;

endmodule

// File: tb/tb_aemb2_xsl_hub.sv
module tb_aemb2_xsl_hub;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rst4;
    logic         sel4;
    logic         cyc, stb, wre, tag, nbk;
    logic [2:0]   adr;
    logic [31:0]  wdat;
    logic         stb8, stb4;

    logic [31:0]  dat8, dat4;
    logic         ack8, flg8, err8, ack4, flg4, err4;
    logic [255:0] txd_dat;
    logic [7:0]   txd_ctl, txd_vld, txd_rdy;
    logic [255:0] rxd_dat;
    logic [7:0]   rxd_ctl, rxd_vld, rxd_rdy;

    logic [127:0] txd4_dat;
    logic [3:0]   txd4_ctl, txd4_vld, rxd4_rdy;
    logic [3:0]   zero4;
    logic [127:0] zero128;

    logic         ack, flg, err;
    logic [31:0]  rdat;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign stb8 = stb & ~sel4;
    assign stb4 = stb & sel4;
    assign ack  = sel4 ? ack4 : ack8;
    assign flg  = sel4 ? flg4 : flg8;
    assign err  = sel4 ? err4 : err8;
    assign rdat = sel4 ? dat4 : dat8;
    assign zero4   = '0;
    assign zero128 = '0;

    aemb2_xsl_hub #(.AEMB_XWB(3), .AEMB_XCH(8), .AEMB_FDP(2)) u_dut (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .xwb_cyc_i(cyc), .xwb_stb_i(stb8), .xwb_wre_i(wre), .xwb_adr_i(adr),
        .xwb_tag_i(tag), .xwb_nbk_i(nbk), .xwb_dat_i(wdat), .xwb_dat_o(dat8),
        .xwb_ack_o(ack8), .xsl_flg_o(flg8), .xsl_err_o(err8),
        .txd_dat_o(txd_dat), .txd_ctl_o(txd_ctl), .txd_vld_o(txd_vld), .txd_rdy_i(txd_rdy),
        .rxd_dat_i(rxd_dat), .rxd_ctl_i(rxd_ctl), .rxd_vld_i(rxd_vld), .rxd_rdy_o(rxd_rdy)
    );

    aemb2_xsl_hub #(.AEMB_XWB(3), .AEMB_XCH(4), .AEMB_FDP(2)) u_dut4 (
        .sys_clk_i(clk), .sys_rst_i(rst4),
        .xwb_cyc_i(cyc), .xwb_stb_i(stb4), .xwb_wre_i(wre), .xwb_adr_i(adr),
        .xwb_tag_i(tag), .xwb_nbk_i(nbk), .xwb_dat_i(wdat), .xwb_dat_o(dat4),
        .xwb_ack_o(ack4), .xsl_flg_o(flg4), .xsl_err_o(err4),
        .txd_dat_o(txd4_dat), .txd_ctl_o(txd4_ctl), .txd_vld_o(txd4_vld), .txd_rdy_i(zero4),
        .rxd_dat_i(zero128), .rxd_ctl_i(zero4), .rxd_vld_i(zero4), .rxd_rdy_o(rxd4_rdy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic core_start(input bit w, input int ch, input bit t, input bit nb, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; wre = w; adr = 3'(ch); tag = t; nbk = nb; wdat = d;
    endtask

    task automatic core_stop();
        cyc = 1'b0; stb = 1'b0; wre = 1'b0; tag = 1'b0; nbk = 1'b0; wdat = '0; adr = '0;
    endtask

    // Waits up to maxc falling edges for ack; lat = edges waited or -1.
    task automatic core_wait(input int maxc, output int lat);
        lat = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                break;
            end
        end
    endtask

    // Entered and left on a falling edge, bus idle on return.
    task automatic core_txn(input bit w, input int ch, input bit t, input bit nb, input logic [31:0] d,
                            output int lat, output logic [31:0] rd, output logic rf, output logic re);
        core_start(w, ch, t, nb, d);
        core_wait(20, lat);
        rd = rdat; rf = flg; re = err;
        core_stop();
        @(negedge clk);
    endtask

    task automatic rx_push(input int ch, input bit c, input logic [31:0] d, output bit acc);
        acc = rxd_rdy[ch];
        rxd_vld[ch] = 1'b1; rxd_ctl[ch] = c; rxd_dat[ch*32 +: 32] = d;
        @(negedge clk);
        rxd_vld[ch] = 1'b0;
    endtask

    task automatic tx_pop(input int ch, output bit v, output logic [32:0] e);
        v = txd_vld[ch];
        e = {txd_ctl[ch], txd_dat[ch*32 +: 32]};
        txd_rdy[ch] = 1'b1;
        @(negedge clk);
        txd_rdy[ch] = 1'b0;
    endtask

    typedef struct {
        bit          pre;
        bit          pctl;
        logic [31:0] pdat;
        bit          w;
        int          ch;
        bit          t;
        bit          nb;
        logic [31:0] d;
        logic [31:0] edat;
        bit          eflg;
        bit          eerr;
    } vec_t;

    vec_t         tbl [8];
    logic [32:0]  txq [N][$];
    logic [32:0]  rxq [N][$];

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        rf, re;
        bit          acc, v;
        logic [32:0] e;

        tbl[0] = '{0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        1, 0};
        tbl[1] = '{0, 0, 32'h0,        1, 5, 1, 0, 32'hA5A50001, 32'h0,        0, 0};
        tbl[2] = '{1, 0, 32'h12345678, 0, 6, 0, 0, 32'h0,        32'h12345678, 0, 0};
        tbl[3] = '{1, 1, 32'hCAFEF00D, 0, 6, 0, 1, 32'h0,        32'hCAFEF00D, 0, 1};
        tbl[4] = '{0, 0, 32'h0,        0, 6, 1, 1, 32'h0,        32'h0,        1, 0};
        tbl[5] = '{0, 0, 32'h0,        1, 5, 0, 1, 32'h5A5A0002, 32'h0,        0, 0};
        tbl[6] = '{1, 1, 32'hFFFFFFFF, 0, 7, 1, 1, 32'h0,        32'hFFFFFFFF, 0, 0};
        tbl[7] = '{0, 0, 32'h0,        0, 7, 1, 1, 32'h0,        32'h0,        1, 0};

        rst = 1'b1; rst4 = 1'b1; sel4 = 1'b0;
        core_stop();
        txd_rdy = '0; rxd_vld = '0; rxd_ctl = '0; rxd_dat = '0;
        #12;
        chk("reset_outs", {ack8, dat8, flg8, err8}, '0);
        chk("reset_txvld", txd_vld, 8'h00);
        chk("reset_rxrdy", rxd_rdy, 8'hFF);
        @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;
        @(negedge clk);

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].pre) rx_push(tbl[i].ch, tbl[i].pctl, tbl[i].pdat, acc);
            core_txn(tbl[i].w, tbl[i].ch, tbl[i].t, tbl[i].nb, tbl[i].d, lat, rd, rf, re);
            chk($sformatf("tbl%0d_lat", i), lat, 1);
            chk($sformatf("tbl%0d_dat", i), rd, tbl[i].edat);
            chk($sformatf("tbl%0d_flg", i), rf, tbl[i].eflg);
            chk($sformatf("tbl%0d_err", i), re, tbl[i].eerr);
            chk($sformatf("tbl%0d_idle", i), {ack8, dat8, flg8, err8}, '0);
        end
        tx_pop(5, v, e);
        chk("tbl_tx5_a", {v, e}, {1'b1, 1'b1, 32'hA5A50001});
        tx_pop(5, v, e);
        chk("tbl_tx5_b", {v, e}, {1'b1, 1'b0, 32'h5A5A0002});

        // Blocking put stall and resume on channel 2
        for (int k = 1; k <= 4; k++) begin
            core_txn(1, 2, 0, 0, 32'(k), lat, rd, rf, re);
            chk($sformatf("bput%0d_lat", k), lat, 1);
        end
        core_start(1, 2, 0, 0, 32'd5);
        core_wait(4, lat);
        chk("bput5_stalled", lat < 0, 1'b1);
        chk("bput_head1", {txd_vld[2], txd_dat[95:64]}, {1'b1, 32'd1});
        txd_rdy[2] = 1'b1;
        @(negedge clk);
        txd_rdy[2] = 1'b0;
        chk("bput5_not_yet", ack, 1'b0);
        @(negedge clk);
        chk("bput5_resume_ack", ack, 1'b1);
        core_stop();
        @(negedge clk);
        for (int k = 2; k <= 5; k++) begin
            tx_pop(2, v, e);
            chk($sformatf("bput_order%0d", k), {v, e[31:0]}, {1'b1, 32'(k)});
        end
        chk("bput_drained", txd_vld[2], 1'b0);

        // Control mismatch on channel 1
        rx_push(1, 1'b1, 32'hDEADBEEF, acc);
        core_txn(0, 1, 0, 0, '0, lat, rd, rf, re);
        chk("mis_resp", {32'(lat), rd, rf, re}, {32'd1, 32'hDEADBEEF, 1'b0, 1'b1});
        core_txn(0, 1, 0, 1, '0, lat, rd, rf, re);
        chk("mis_after_empty", {32'(lat), rd, rf, re}, {32'd1, 32'h0, 1'b1, 1'b0});

        // Full RX FIFO on channel 3 with coincident pop and push
        for (int k = 0; k < 4; k++) begin
            rx_push(3, 1'b0, 32'h300 + 32'(k), acc);
            chk($sformatf("rx3_fill%0d", k), acc, 1'b1);
        end
        rxd_vld[3] = 1'b1; rxd_ctl[3] = 1'b0; rxd_dat[127:96] = 32'h3E5;
        core_start(0, 3, 0, 0, '0);
        chk("rx3_rdy_full", rxd_rdy[3], 1'b0);
        @(negedge clk);
        chk("rx3_get_ack", {ack, rdat}, {1'b1, 32'h300});
        chk("rx3_rdy_after_pop", rxd_rdy[3], 1'b1);
        core_stop();
        @(negedge clk);
        rxd_vld[3] = 1'b0;
        chk("rx3_refull", rxd_rdy[3], 1'b0);
        for (int k = 1; k <= 4; k++) begin
            core_txn(0, 3, 0, 0, '0, lat, rd, rf, re);
            chk($sformatf("rx3_drain%0d", k), {32'(lat), rd},
                {32'd1, (k == 4) ? 32'h3E5 : 32'h300 + 32'(k)});
        end

        // Asynchronous reset while an ack is showing
        rx_push(4, 1'b0, 32'h44, acc);
        core_txn(1, 4, 0, 0, 32'h4444, lat, rd, rf, re);
        chk("pre_reset_txvld", txd_vld[4], 1'b1);
        core_start(0, 0, 0, 1, '0);
        @(posedge clk);
        #2;
        chk("pre_reset_ack", {ack, flg}, 2'b11);
        rst = 1'b1;
        #1;
        chk("async_reset_outs", {ack8, dat8, flg8, err8}, '0);
        chk("async_reset_txvld", txd_vld, 8'h00);
        chk("async_reset_rxrdy", rxd_rdy, 8'hFF);
        core_stop();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        core_txn(0, 4, 0, 1, '0, lat, rd, rf, re);
        chk("reset_flushed_rx", {32'(lat), rd, rf}, {32'd1, 32'h0, 1'b1});

        // Bad channel and reset during a stall on the 4-channel hub
        sel4 = 1'b1;
        core_txn(0, 6, 0, 0, '0, lat, rd, rf, re);
        chk("bad_get", {32'(lat), rd, rf, re}, {32'd1, 32'h0, 1'b0, 1'b1});
        core_txn(1, 4, 1, 0, 32'h12, lat, rd, rf, re);
        chk("bad_put", {32'(lat), rd, rf, re}, {32'd1, 32'h0, 1'b0, 1'b1});
        chk("bad_idle", {ack4, dat4, flg4, err4}, '0);
        core_start(0, 0, 0, 0, '0);
        core_wait(3, lat);
        chk("stall4_no_ack", lat < 0, 1'b1);
        rst4 = 1'b1;
        core_stop();
        @(negedge clk);
        rst4 = 1'b0;
        core_wait(3, lat);
        chk("stall4_dropped", lat < 0, 1'b1);
        core_txn(0, 0, 0, 1, '0, lat, rd, rf, re);
        chk("stall4_idle_after", {32'(lat), rd, rf, re}, {32'd1, 32'h0, 1'b1, 1'b0});
        sel4 = 1'b0;

        // Randomized traffic against a queue model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int it = 0; it < 400; it++) begin
            int          op, ch;
            bit          t, nb, full, empty;
            logic [31:0] d, edat;
            bit          eflg, eerr;
            op = int'($urandom_range(0, 3));
            ch = int'($urandom_range(0, N - 1));
            t  = 1'($urandom);
            d  = $urandom;
            case (op)
                0: begin
                    full = (txq[ch].size() == D);
                    nb   = full | 1'($urandom);
                    if (!full) txq[ch].push_back({t, d});
                    core_txn(1, ch, t, nb, d, lat, rd, rf, re);
                    chk($sformatf("rnd%0d_put", it), {32'(lat), rd, rf, re}, {32'd1, 32'h0, full, 1'b0});
                end
                1: begin
                    empty = (rxq[ch].size() == 0);
                    nb    = empty | 1'($urandom);
                    edat = '0; eflg = 1'b1; eerr = 1'b0;
                    if (!empty) begin
                        e    = rxq[ch].pop_front();
                        edat = e[31:0];
                        eflg = 1'b0;
                        eerr = (e[32] != t);
                    end
                    core_txn(0, ch, t, nb, '0, lat, rd, rf, re);
                    chk($sformatf("rnd%0d_get", it), {32'(lat), rd, rf, re}, {32'd1, edat, eflg, eerr});
                end
                2: begin
                    full = (rxq[ch].size() == D);
                    rx_push(ch, t, d, acc);
                    chk($sformatf("rnd%0d_rxrdy", it), acc, !full);
                    if (!full) rxq[ch].push_back({t, d});
                end
                default: begin
                    empty = (txq[ch].size() == 0);
                    tx_pop(ch, v, e);
                    chk($sformatf("rnd%0d_txvld", it), v, !empty);
                    if (!empty) chk($sformatf("rnd%0d_txhead", it), e, txq[ch].pop_front());
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
